// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the shared-ALU arbiter
package alu_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_arb_state_t;
  localparam int ALU_ARB_NREQ = 2;
  localparam int ALU_ARB_SEL_W = 4;
  localparam logic [ALU_ARB_SEL_W-1:0] ALU_ARB_RST_SEL = '0;
endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: one-hot winner select; ALU_ARB_FIXED_PRIO_EN gives requester 0 fixed priority
module alu_arb_pick
  import alu_arb_pkg::*;
(
  input  logic [ALU_ARB_NREQ-1:0] req_valid,
  input  logic                    last_grant,
  output logic [ALU_ARB_NREQ-1:0] grant
);
  // a lone requester always wins; contention resolved by priority mode
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant = (req_valid == 2'b11) ? 2'b01 : req_valid;
`else
    grant = (req_valid == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req_valid;
`endif
  end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: two-requester arbiter/sequencer for the shared ALU (ALU_ARB_FIXED_PRIO_EN selects fixed priority)
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int SEL_W     = ALU_ARB_SEL_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ALU_ARB_NREQ-1:0]     req_valid,
  output logic [ALU_ARB_NREQ-1:0]     req_ready,
  input  logic [2*WORD_SIZE-1:0]      req_a,
  input  logic [2*WORD_SIZE-1:0]      req_b,
  input  logic [2*SEL_W-1:0]          req_sel,
  output logic [ALU_ARB_NREQ-1:0]     rsp_valid,
  input  logic [ALU_ARB_NREQ-1:0]     rsp_ready,
  output logic [WORD_SIZE-1:0]        rsp_data,
  output logic                        rsp_zero,
  output logic [WORD_SIZE-1:0]        alu_a,
  output logic [WORD_SIZE-1:0]        alu_b,
  output logic [SEL_W-1:0]            alu_sel,
  input  logic [WORD_SIZE-1:0]        alu_result,
  input  logic                        alu_zero
);
  alu_arb_state_t state, state_nxt;
  logic [WORD_SIZE-1:0] op_a, op_b;
  logic [SEL_W-1:0] op_sel;
  logic grant_id, last_grant, g;
  logic [ALU_ARB_NREQ-1:0] grant;

  alu_arb_pick u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign g = req_ready[1];
  assign alu_a = op_a;
  assign alu_b = op_b;
  assign alu_sel = op_sel;

  // handshake outputs; ready is masked during reset so outputs read as reset values
  always_comb begin
    req_ready = (state == IDLE && rst_n) ? grant : '0;
    rsp_valid = (state == RESP) ? {grant_id, ~grant_id} : '0;
  end

  // next state: one accept, one execute cycle, then hold the response until taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = |req_ready ? EXEC : IDLE;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = rsp_ready[grant_id] ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // state, operand latch on accept, result capture at the end of execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= SEL_W'(ALU_ARB_RST_SEL);
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |req_ready) begin
        op_a       <= req_a[g*WORD_SIZE +: WORD_SIZE];
        op_b       <= req_b[g*WORD_SIZE +: WORD_SIZE];
        op_sel     <= req_sel[g*SEL_W +: SEL_W];
        grant_id   <= g;
        last_grant <= g;
      end
      if (state == EXEC) begin
        rsp_data <= alu_result;
        rsp_zero <= alu_zero;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed and random transactions against a transaction-level model
module tb_alu_share_arb;
  logic clk = 0, rst_n = 0;
  logic [1:0] req_valid = 0, req_ready, rsp_valid, rsp_ready = 0;
  logic [63:0] req_a = 0, req_b = 0;
  logic [7:0] req_sel = 0;
  logic [31:0] rsp_data, alu_a, alu_b, alu_result;
  logic [3:0] alu_sel;
  logic rsp_zero, alu_zero;
  int checks = 0, errors = 0, prev = 1;

  always #5 clk = ~clk;
  assign alu_result = alu_a - alu_b;
  assign alu_zero = (alu_result == 0);

  alu_share_arb dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] m);
    if (m == 2'b11)
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return 1 - prev;
`endif
    return m[1] ? 1 : 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_sel[i*4 +: 4] = s;
  endtask

  task automatic run_txn(input logic [1:0] mask, input int bp);
    int w;
    logic [1:0] oh;
    logic [31:0] ea, eb, er;
    logic [3:0] es;
    req_valid = mask;
    w = pick(mask);
    oh = (w == 1) ? 2'b10 : 2'b01;
    ea = req_a[w*32 +: 32];
    eb = req_b[w*32 +: 32];
    es = req_sel[w*4 +: 4];
    er = ea - eb;
    rsp_ready = (bp == 0) ? 2'b11 : ~oh;
    #1 chk("req_ready_accept", req_ready, oh);
    cyc();
    prev = w;
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("alu_sel", alu_sel, es);
    chk("rsp_valid_exec", rsp_valid, 0);
    chk("req_ready_exec", req_ready, 0);
    set_req(w, $urandom, $urandom, 4'($urandom));
    cyc();
    for (int k = 0; k < bp; k++) begin
      chk("rsp_valid_hold", rsp_valid, oh);
      chk("rsp_data_hold", rsp_data, er);
      chk("req_ready_hold", req_ready, 0);
      cyc();
    end
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_data", rsp_data, er);
    chk("rsp_zero", rsp_zero, (er == 0));
    rsp_ready = 2'b11;
    cyc();
    rsp_ready = 0;
    chk("rsp_valid_done", rsp_valid, 0);
  endtask

  initial begin
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_sel", alu_sel, 0);
    @(negedge clk);
    rst_n = 1;
    cyc();
    chk("idle_no_req", req_ready, 0);
    set_req(0, 12, 10, 5);
    run_txn(2'b01, 0);
    set_req(1, 5, 5, 1);
    run_txn(2'b10, 0);
    for (int k = 0; k < 4; k++) run_txn(2'b11, 0);
    set_req(0, 100, 7, 3);
    run_txn(2'b01, 5);
    set_req(1, 9, 4, 2);
    req_valid = 2'b10;
    #1 chk("mid_accept", req_ready, 2'b10);
    cyc();
    rst_n = 0;
    #1;
    chk("abort_req_ready", req_ready, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_rsp_zero", rsp_zero, 0);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_alu_b", alu_b, 0);
    chk("abort_alu_sel", alu_sel, 0);
    prev = 1;
    @(negedge clk);
    rst_n = 1;
    req_valid = 0;
    cyc();
    chk("no_stale_rsp", rsp_valid, 0);
    run_txn(2'b11, 0);
    for (int n = 0; n < 24; n++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        logic [31:0] a;
        a = $urandom;
        set_req(i, a, ($urandom_range(0, 3) == 0) ? a : $urandom, 4'($urandom));
      end
      run_txn(m, $urandom_range(0, 3));
    end
    req_valid = 0;
    cyc();
    chk("final_idle", req_ready, 0);
    chk("final_rsp", rsp_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
